// File: rtl/encoder8_3_seq.sv
// Registered 8-to-3 priority encoder with sticky request capture.
// Pending indices drain one per handshake, highest priority first.
module encoder8_3_seq #(
  parameter bit PRIORITY_HIGH = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] I,
  output logic [2:0] Y,
  output logic       valid,
  input  logic       ready,
  output logic [7:0] pending,
  output logic       dup
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;

  logic [7:0] r_pending;
  logic [2:0] r_y;
  logic       r_valid;
  logic       r_dup;

  logic [7:0] w_set;
  logic [7:0] w_clr;
  logic [2:0] w_idx;
  logic       w_any;
  logic       w_issue;
  logic       w_valid_nxt;

  assign w_set = en ? I : 8'h00;
  assign w_any = |r_pending;

  // Later loop iterations override earlier ones, so scan order sets priority.
  always_comb begin
    w_idx = 3'd0;
    if (PRIORITY_HIGH) begin
      for (int k = 0; k < 8; k++) begin
        if (r_pending[k]) w_idx = 3'(k);
      end
    end else begin
      for (int k = 7; k >= 0; k--) begin
        if (r_pending[k]) w_idx = 3'(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (w_any) w_state_nxt = S_HOLD;
      S_HOLD: if (ready && !w_any) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_issue     = 1'b0;
    w_valid_nxt = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_issue     = w_any;
        w_valid_nxt = w_any;
      end
      S_HOLD: begin
        w_issue     = ready && w_any;
        w_valid_nxt = !ready || w_any;
      end
      default: begin
        w_issue     = 1'b0;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  assign w_clr = w_issue ? (8'h01 << w_idx) : 8'h00;

  // A new request on the bit being issued wins over its clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= 8'h00;
      r_y       <= 3'd0;
      r_valid   <= 1'b0;
      r_dup     <= 1'b0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_set;
      r_dup     <= |(w_set & r_pending);
      r_valid   <= w_valid_nxt;
      if (w_issue) r_y <= w_idx;
    end
  end

  assign Y       = r_y;
  assign valid   = r_valid;
  assign pending = r_pending;
  assign dup     = r_dup;

endmodule

// File: tb/tb_encoder8_3_seq.sv
// Bench for encoder8_3_seq: both priority orders against a
// behavioural model, plus directed literal expectations.
module tb_encoder8_3_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       ready = 1'b0;
  logic [7:0] I = 8'h00;

  logic [2:0] y_h, y_l;
  logic       v_h, v_l;
  logic [7:0] pend_h, pend_l;
  logic       dup_h, dup_l;

  int total = 0;
  int pass = 0;

  always #5 clk = ~clk;

  encoder8_3_seq #(.PRIORITY_HIGH(1'b1)) u_hi (
    .clk(clk), .rst(rst), .en(en), .I(I),
    .Y(y_h), .valid(v_h), .ready(ready),
    .pending(pend_h), .dup(dup_h)
  );

  encoder8_3_seq #(.PRIORITY_HIGH(1'b0)) u_lo (
    .clk(clk), .rst(rst), .en(en), .I(I),
    .Y(y_l), .valid(v_l), .ready(ready),
    .pending(pend_l), .dup(dup_l)
  );

  typedef struct packed {
    logic [7:0] pend;
    logic [2:0] y;
    logic       v;
    logic       d;
  } mst_t;

  mst_t mh = '0;
  mst_t ml = '0;
  bit   live = 1'b0;

  function automatic int pick(logic [7:0] p, bit hi);
    for (int j = 0; j < 8; j++) begin
      int b;
      b = hi ? 7 - j : j;
      if (p[b]) return b;
    end
    return 0;
  endfunction

  function automatic mst_t mstep(mst_t s, bit hi, logic r,
                                 logic e, logic [7:0] i, logic rd);
    mst_t n;
    logic [7:0] set;
    int k;
    if (r) return '0;
    set = e ? i : 8'h00;
    n = s;
    n.d = (set & s.pend) != 8'h00;
    if (s.pend != 8'h00 && (!s.v || rd)) begin
      k = pick(s.pend, hi);
      n.y = 3'(k);
      n.v = 1'b1;
      n.pend = (s.pend & ~(8'h01 << k)) | set;
    end else begin
      if (s.v && rd) n.v = 1'b0;
      n.pend = s.pend | set;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    mh <= mstep(mh, 1'b1, rst, en, I, ready);
    ml <= mstep(ml, 1'b0, rst, en, I, ready);
    if (rst) live <= 1'b1;
  end

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (live) begin
      chk("m_y_h", 8'(y_h), 8'(mh.y));
      chk("m_v_h", 8'(v_h), 8'(mh.v));
      chk("m_pend_h", pend_h, mh.pend);
      chk("m_dup_h", 8'(dup_h), 8'(mh.d));
      chk("m_y_l", 8'(y_l), 8'(ml.y));
      chk("m_v_l", 8'(v_l), 8'(ml.v));
      chk("m_pend_l", pend_l, ml.pend);
      chk("m_dup_l", 8'(dup_l), 8'(ml.d));
    end
  end

  task automatic tick(logic r, logic e, logic [7:0] i, logic rd);
    rst = r;
    en = e;
    I = i;
    ready = rd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int seqh[3];
    int seql[3];
    seqh = '{7, 5, 2};
    seql = '{2, 5, 7};

    tick(1, 1, 8'h00, 1);
    chk("rst_pend", pend_h, 8'h00);
    chk("rst_v", 8'(v_h), 8'h00);
    chk("rst_y", 8'(y_h), 8'h00);
    chk("rst_dup", 8'(dup_h), 8'h00);

    tick(0, 1, 8'h10, 1);
    chk("t1_pend", pend_h, 8'h10);
    chk("t1_v0", 8'(v_h), 8'h00);
    tick(0, 1, 8'h00, 1);
    chk("t1_y_h", 8'(y_h), 8'h04);
    chk("t1_v1", 8'(v_h), 8'h01);
    chk("t1_pend0", pend_h, 8'h00);
    chk("t1_y_l", 8'(y_l), 8'h04);
    tick(0, 1, 8'h00, 1);
    chk("t1_vend", 8'(v_h), 8'h00);

    tick(0, 1, 8'hA4, 1);
    chk("t2_pend_h", pend_h, 8'hA4);
    chk("t2_pend_l", pend_l, 8'hA4);
    for (int j = 0; j < 3; j++) begin
      tick(0, 1, 8'h00, 1);
      chk("t2_y_h", 8'(y_h), 8'(seqh[j]));
      chk("t2_y_l", 8'(y_l), 8'(seql[j]));
      chk("t2_v_h", 8'(v_h), 8'h01);
      chk("t2_v_l", 8'(v_l), 8'h01);
    end
    tick(0, 1, 8'h00, 1);
    chk("t2_vend_h", 8'(v_h), 8'h00);
    chk("t2_vend_l", 8'(v_l), 8'h00);

    tick(0, 1, 8'h81, 0);
    tick(0, 1, 8'h00, 0);
    chk("t3_y_h", 8'(y_h), 8'h07);
    chk("t3_pend_h", pend_h, 8'h01);
    chk("t3_y_l", 8'(y_l), 8'h00);
    chk("t3_pend_l", pend_l, 8'h80);
    repeat (3) begin
      tick(0, 1, 8'h00, 0);
      chk("t3_hold_y", 8'(y_h), 8'h07);
      chk("t3_hold_v", 8'(v_h), 8'h01);
    end
    tick(0, 1, 8'h80, 0);
    chk("t3_rereq_pend", pend_h, 8'h81);
    chk("t3_rereq_dup", 8'(dup_h), 8'h00);
    chk("t3_rereq_y", 8'(y_h), 8'h07);
    chk("t3_dup_l", 8'(dup_l), 8'h01);
    tick(0, 1, 8'h00, 1);
    chk("t3_rel_y7", 8'(y_h), 8'h07);
    chk("t3_rel_pend", pend_h, 8'h01);
    chk("t3_rel_v", 8'(v_h), 8'h01);
    tick(0, 1, 8'h00, 1);
    chk("t3_rel_y0", 8'(y_h), 8'h00);
    chk("t3_rel_pend0", pend_h, 8'h00);
    tick(0, 1, 8'h00, 1);
    chk("t3_vend", 8'(v_h), 8'h00);

    tick(0, 1, 8'h18, 0);
    tick(0, 1, 8'h00, 0);
    chk("t4_pend", pend_h, 8'h08);
    tick(0, 1, 8'h08, 0);
    chk("t4_dup1", 8'(dup_h), 8'h01);
    chk("t4_pend_same", pend_h, 8'h08);
    tick(0, 1, 8'h00, 0);
    chk("t4_dup0", 8'(dup_h), 8'h00);
    chk("t4_pend_keep", pend_h, 8'h08);
    repeat (4) tick(0, 1, 8'h00, 1);
    chk("t4_vend_h", 8'(v_h), 8'h00);
    chk("t4_vend_l", 8'(v_l), 8'h00);

    tick(0, 1, 8'h06, 1);
    tick(0, 0, 8'hFF, 1);
    chk("t5_y2", 8'(y_h), 8'h02);
    chk("t5_pend02", pend_h, 8'h02);
    chk("t5_dup_a", 8'(dup_h), 8'h00);
    tick(0, 0, 8'hFF, 1);
    chk("t5_y1", 8'(y_h), 8'h01);
    chk("t5_pend00", pend_h, 8'h00);
    chk("t5_dup_b", 8'(dup_h), 8'h00);
    tick(0, 0, 8'hFF, 1);
    chk("t5_vend", 8'(v_h), 8'h00);
    chk("t5_pend_end", pend_h, 8'h00);
    chk("t5_dup_c", 8'(dup_h), 8'h00);

    tick(0, 1, 8'h0F, 1);
    tick(0, 1, 8'h00, 1);
    chk("t6_y3", 8'(y_h), 8'h03);
    tick(0, 1, 8'h00, 1);
    chk("t6_y2", 8'(y_h), 8'h02);
    chk("t6_v", 8'(v_h), 8'h01);
    chk("t6_pend", pend_h, 8'h03);
    tick(1, 1, 8'hFF, 1);
    chk("t6_rst_pend", pend_h, 8'h00);
    chk("t6_rst_v", 8'(v_h), 8'h00);
    chk("t6_rst_y", 8'(y_h), 8'h00);
    chk("t6_rst_dup", 8'(dup_h), 8'h00);
    chk("t6_rst_pend_l", pend_l, 8'h00);
    chk("t6_rst_v_l", 8'(v_l), 8'h00);
    repeat (2) begin
      tick(0, 1, 8'h00, 1);
      chk("t6_quiet_v", 8'(v_h), 8'h00);
      chk("t6_quiet_pend", pend_h, 8'h00);
    end

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule

// File: doc/encoder8_3_seq.md
Name: encoder8_3_seq

Overview:
- Registered 8-to-3 priority encoder with request capture. It is the inverse companion of the 3-to-8 decoder.
- Accepts one-cycle request pulses on 8 lines and holds them in a sticky pending register.
- Emits pending indices one at a time as a 3-bit code over a valid/ready handshake, clearing each bit as it is issued.
- Used to turn scattered one-hot events (interrupts, slot-done flags) back into binary indices for downstream logic.

Parameters:
- PRIORITY_HIGH, 1, 1 = bit 7 has highest priority; 0 = bit 0 has highest priority.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- en  input  1  capture enable for I; when low, I is ignored but draining continues
- I  input  8  request pulses, one bit per index
- Y  output  3  encoded index of the issued request (registered)
- valid  output  1  Y holds an issued index (registered)
- ready  input  1  consumer accepts Y this cycle when valid=1
- pending  output  8  current pending register; excludes the index held in Y
- dup  output  1  one-cycle pulse: a captured request hit a bit that was already pending

Behaviour:
- Clock, reset and polarity (decided): one clock, clk. Reset rst is synchronous and active-high.
- Reset:
  - Sampled on the clk edge.
  - Sets pending=0, Y=0, valid=0, dup=0 and FSM=IDLE.
  - Overrides all other activity in that cycle, including mid-handshake. An issued-but-unaccepted index is discarded.
- Capture:
  - set = en ? I : 8'h00.
  - Next pending = (pending & ~clr) | set, where clr is the one-hot bit being issued this cycle.
  - If set and clr hit the same bit in the same cycle, set wins and the bit stays pending.
- dup:
  - Registered: dup <= |(set & pending) in the same cycle.
  - The index currently held in Y is not in pending, so a re-request of it does not raise dup. It re-pends normally.
- Select:
  - idx = highest-priority set bit of the registered pending, per PRIORITY_HIGH.
  - Only the registered value is used; bits captured this cycle are never considered.
- FSM, 2 states:
  - IDLE (valid=0):
    - pending != 0: Y<=idx, valid<=1, clr=onehot(idx), go HOLD.
    - Otherwise stay in IDLE. Y keeps its last value.
  - HOLD (valid=1):
    - Y and valid stay stable while ready=0. Higher-priority arrivals do not preempt the held Y.
    - ready=1 and pending != 0: back-to-back issue. Y<=idx, clr=onehot(idx), stay in HOLD, valid stays 1.
    - ready=1 and pending == 0: valid<=0, go IDLE.
- Latency:
  - I pulsed in cycle 0 sets pending after edge 1.
  - valid/Y appear after edge 2 if the FSM was idle.
- Throughput: one index per cycle while ready=1 and pending != 0.
- Encoding: Y is the binary index 0..7. All-zero pending produces no issue; there is no invalid code because valid gates Y.
- Multiple simultaneous requests are issued in strict priority order. Lower indices can starve if high indices are re-requested continuously; this is accepted.

Test Plan:
- Reset, then I=8'h10 for one cycle with en=1, ready=1 -> pending=8'h10 after edge 1; Y=4, valid=1 after edge 2; valid=0 and pending=0 one cycle later.
- I=8'hA4 in one cycle, ready=1, PRIORITY_HIGH=1 -> Y sequence 7,5,2 on consecutive cycles with valid continuously high, then valid=0. Rerun with PRIORITY_HIGH=0 -> 2,5,7.
- I=8'h81, ready=0 for 5 cycles -> Y=7 held stable, pending=8'h01. Pulse I[7] during the hold -> pending=8'h81, dup=0. Release ready -> Y sequence 7,0, and the re-requested 7 is issued before 0.
- With pending=8'h08 held because ready=0, pulse I=8'h08 -> dup=1 for exactly one cycle, pending stays 8'h08.
- en=0 with I=8'hFF for 3 cycles -> pending unchanged, no dup, draining of existing pending continues.
- I=8'h0F, ready=1, assert rst on the cycle Y=2 is issued -> next cycle pending=0, valid=0, Y=0, dup=0, and no further issues.
